// File: rtl/ex_tracker.sv
// ex_tracker: buffers completed ID-stage trace elements, stamps EX start/end
// times from the global counter and hands each element on to the WB tracker.
`default_nettype none

module ex_tracker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [31:0]                          counter,
    input  logic                                 id_data_ready,
    input  logic [ADDR_WIDTH+DATA_WIDTH+256:0]   id_data_in,
    input  logic                                 is_executing,
    output logic [ADDR_WIDTH+DATA_WIDTH+256:0]   ex_data_o,
    output logic                                 ex_data_ready,
    output logic                                 overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Packed layout of a trace element, MSB first; pass_through is bit 0.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] instruction;
        logic [31:0]           if_start;
        logic [31:0]           if_end;
        logic [31:0]           id_start;
        logic [31:0]           id_end;
        logic [31:0]           ex_start;
        logic [31:0]           ex_end;
        logic [31:0]           wb_start;
        logic [31:0]           wb_end;
        logic                  pass_through;
    } trace_t;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_EXEC_START = 2'd1,
        S_EXEC_END   = 2'd2
    } state_t;

    trace_t                r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    trace_t                r_work;
    trace_t                r_out;
    logic                  r_pt_pend;
    logic                  r_ready;
    logic                  r_ovf;
    logic                  r_id_ready_d;
    logic [DATA_WIDTH-1:0] r_last_instr;
    state_t                r_state;

    trace_t w_in;
    trace_t w_head;
    trace_t w_popped;
    trace_t w_emit_data;
    state_t w_state_nxt;
    logic   w_capture;
    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    logic   w_drop;
    logic   w_emit;
    logic   w_load_start;

    assign w_in      = id_data_in;
    assign w_head    = r_mem[r_rd_ptr];
    // A held level only counts again once the instruction changes.
    assign w_capture = id_data_ready && (!r_id_ready_d || (w_in.instruction != r_last_instr));
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    always_comb begin
        w_state_nxt           = r_state;
        w_pop                 = 1'b0;
        w_load_start          = 1'b0;
        w_emit                = r_pt_pend;
        w_emit_data           = r_work;
        w_popped              = w_head;
        w_popped.ex_start     = '0;
        w_popped.ex_end       = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (!w_head.pass_through) begin
                        w_state_nxt = S_EXEC_START;
                    end
                end
            end
            S_EXEC_START: begin
                if (is_executing) begin
                    w_load_start = 1'b1;
                    w_state_nxt  = S_EXEC_END;
                end
            end
            S_EXEC_END: begin
                if (!is_executing) begin
                    w_emit             = 1'b1;
                    w_emit_data.ex_end = counter;
                    w_state_nxt        = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_work       <= '0;
            r_out        <= '0;
            r_pt_pend    <= 1'b0;
            r_ready      <= 1'b0;
            r_ovf        <= 1'b0;
            r_id_ready_d <= 1'b0;
            r_last_instr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_id_ready_d <= id_data_ready;
            r_ready      <= w_emit;
            r_ovf        <= r_ovf | w_drop;
            r_pt_pend    <= w_pop && w_head.pass_through;
            if (w_capture) begin
                r_last_instr <= w_in.instruction;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_work <= w_popped;
            end else if (w_load_start) begin
                r_work.ex_start <= counter;
            end
            if (w_emit) begin
                r_out <= w_emit_data;
            end
        end
    end

    assign ex_data_o     = r_out;
    assign ex_data_ready = r_ready;
    assign overflow      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ex_tracker.sv
// Bench for ex_tracker: directed scenarios plus random traffic against a
// queue-based model of the tracker's observable behaviour.
`default_nettype none

module tb_ex_tracker;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int TW    = AW + DW + 257;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] instr;
        logic [31:0]   if_s;
        logic [31:0]   if_e;
        logic [31:0]   id_s;
        logic [31:0]   id_e;
        logic [31:0]   ex_s;
        logic [31:0]   ex_e;
        logic [31:0]   wb_s;
        logic [31:0]   wb_e;
        logic          pt;
    } elem_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   counter = '0;
    logic          id_ready = 1'b0;
    elem_t         id_in = '0;
    logic          exec = 1'b0;
    logic [TW-1:0] dout;
    logic          drdy;
    logic          ovf;

    always #5 clk = ~clk;

    ex_tracker #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .counter      (counter),
        .id_data_ready(id_ready),
        .id_data_in   (id_in),
        .is_executing (exec),
        .ex_data_o    (dout),
        .ex_data_ready(drdy),
        .overflow     (ovf)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    elem_t       mq[$];
    elem_t       cur;
    int          phase;      // 0 free, 1 waiting for EX start, 2 waiting for EX end
    bit          pt_pend;
    elem_t       pt_elem;
    elem_t       exp_out;
    bit          exp_rdy;
    bit          exp_ovf;
    bit          prev_rdy;
    logic [31:0] last_instr;

    elem_t       seen_e[$];
    logic [31:0] seen_c[$];

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic elem_t mk(input logic [31:0] instr, input bit pt);
        elem_t e;
        e.addr  = $urandom;
        e.instr = instr;
        e.if_s  = $urandom;
        e.if_e  = $urandom;
        e.id_s  = $urandom;
        e.id_e  = $urandom;
        e.ex_s  = $urandom;
        e.ex_e  = $urandom;
        e.wb_s  = $urandom;
        e.wb_e  = $urandom;
        e.pt    = pt;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        cur        = '0;
        phase      = 0;
        pt_pend    = 0;
        pt_elem    = '0;
        exp_out    = '0;
        exp_rdy    = 0;
        exp_ovf    = 0;
        prev_rdy   = 0;
        last_instr = '0;
    endtask

    // One rising edge of the tracker, evaluated on the inputs present at that edge.
    task automatic model_edge();
        elem_t e;
        int    old_phase;
        bit    cap;
        old_phase = phase;
        exp_rdy   = 0;
        if (pt_pend) begin
            exp_out = pt_elem;
            exp_rdy = 1;
            pt_pend = 0;
        end
        if (old_phase == 2 && !exec) begin
            e       = cur;
            e.ex_e  = counter;
            exp_out = e;
            exp_rdy = 1;
            phase   = 0;
        end else if (old_phase == 1 && exec) begin
            cur.ex_s = counter;
            phase    = 2;
        end
        if (old_phase == 0 && mq.size() > 0) begin
            e      = mq.pop_front();
            e.ex_s = '0;
            e.ex_e = '0;
            if (e.pt) begin
                pt_elem = e;
                pt_pend = 1;
            end else begin
                cur   = e;
                phase = 1;
            end
        end
        cap = id_ready && (!prev_rdy || id_in.instr != last_instr);
        if (cap) begin
            last_instr = id_in.instr;
            if (mq.size() < DEPTH) mq.push_back(id_in);
            else exp_ovf = 1;
        end
        prev_rdy = id_ready;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ex_data_ready", drdy, exp_rdy);
        check("overflow", ovf, exp_ovf);
        check("ex_data_o", dout, exp_out);
        if (drdy) begin
            seen_e.push_back(elem_t'(dout));
            seen_c.push_back(counter);
        end
        counter = counter + 1;
    endtask

    // Assert reset away from the clock edge and confirm it acts without a clock.
    task automatic do_reset();
        rst      = 1'b1;
        id_ready = 1'b0;
        #1;
        check("async_rst_ready", drdy, '0);
        check("async_rst_overflow", ovf, '0);
        check("async_rst_data", dout, '0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_ready", drdy, '0);
        rst = 1'b0;
        seen_e.delete();
        seen_c.delete();
    endtask

    elem_t els[4];
    elem_t ref_e;
    logic [31:0] pool[4];

    initial begin
        #2;
        do_reset();

        // Single timed element: EX busy while counter is 20..24
        counter  = 15;
        exec     = 1'b0;
        ref_e    = mk(32'h00A00093, 1'b0);
        id_in    = ref_e;
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        while (counter < 20) step();
        exec = 1'b1;
        while (counter < 25) step();
        exec = 1'b0;
        repeat (3) step();
        check("single_count", seen_e.size(), 1);
        if (seen_e.size() > 0) begin
            check("single_tstart", seen_e[0].ex_s, 32'd20);
            check("single_tend", seen_e[0].ex_e, 32'd25);
            check("single_instr", seen_e[0].instr, 32'h00A00093);
            check("single_other", {seen_e[0].addr, seen_e[0].if_s, seen_e[0].id_e, seen_e[0].wb_s},
                  {ref_e.addr, ref_e.if_s, ref_e.id_e, ref_e.wb_s});
        end

        // Pass-through element: strobe two cycles after capture regardless of EX
        do_reset();
        exec     = 1'b1;
        counter  = 100;
        id_in    = mk(32'h00100013, 1'b1);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        repeat (4) step();
        check("pt_count", seen_e.size(), 1);
        if (seen_e.size() > 0) begin
            check("pt_strobe_cycle", seen_c[0], 32'd102);
            check("pt_exdata_zero", {seen_e[0].ex_s, seen_e[0].ex_e}, '0);
        end
        exec = 1'b0;

        // Ready held ten cycles on one instruction
        do_reset();
        id_in    = mk(32'h12345678, 1'b0);
        id_ready = 1'b1;
        repeat (10) step();
        id_ready = 1'b0;
        exec     = 1'b1;
        repeat (2) step();
        exec = 1'b0;
        repeat (4) step();
        check("held_ready_emits", seen_e.size(), 1);

        // Four distinct elements while EX is stuck busy
        do_reset();
        exec = 1'b1;
        for (int i = 0; i < 4; i++) els[i] = mk(32'hA000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            id_in    = els[i];
            id_ready = 1'b1;
            step();
        end
        id_ready = 1'b0;
        step();
        check("ovf_set_literal", ovf, 1);
        for (int i = 0; i < 40; i++) begin
            exec = (i % 4) != 0;
            step();
        end
        exec = 1'b0;
        repeat (5) step();
        check("ovf_emit_count", seen_e.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < seen_e.size()) check("ovf_order", seen_e[i].instr, els[i].instr);
        end
        check("ovf_sticky", ovf, 1);

        // Reset while waiting for EX to end
        do_reset();
        id_in    = mk(32'h0000_1111, 1'b1);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        repeat (3) step();
        id_in    = mk(32'h0000_2222, 1'b0);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        step();
        exec = 1'b1;
        repeat (2) step();
        do_reset();
        exec     = 1'b1;
        repeat (3) step();
        check("post_rst_no_emit", seen_e.size(), 0);
        exec     = 1'b0;
        counter  = 200;
        id_in    = mk(32'h0000_3333, 1'b0);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        repeat (2) step();
        exec = 1'b1;
        repeat (2) step();
        exec = 1'b0;
        repeat (2) step();
        check("post_rst_count", seen_e.size(), 1);
        if (seen_e.size() > 0) begin
            check("post_rst_tstart", seen_e[0].ex_s, 32'd203);
            check("post_rst_tend", seen_e[0].ex_e, 32'd205);
        end

        // Counter wrapping through the sign boundary during EX
        do_reset();
        counter  = 32'h7FFF_FFFD;
        id_in    = mk(32'h0000_4444, 1'b0);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        step();
        exec = 1'b1;
        step();
        exec = 1'b0;
        repeat (2) step();
        check("wrap_count", seen_e.size(), 1);
        if (seen_e.size() > 0) begin
            check("wrap_tstart", seen_e[0].ex_s, 32'h7FFF_FFFF);
            check("wrap_tend", seen_e[0].ex_e, 32'h8000_0000);
        end

        // Random traffic
        do_reset();
        for (int i = 0; i < 4; i++) pool[i] = $urandom;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) id_ready = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 2) == 0) id_in = mk(pool[$urandom_range(0, 3)], $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) exec = ~exec;
            if ($urandom_range(0, 199) == 0) counter = $urandom;
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
